// File: rtl/cmd_engine_if.sv
// cmd_engine_if: byte-in, register-bank and tx handshake bundle for cmd_engine
// master (engine): takes byte_ready/reg_usb_data_in, reg_data_out, tx_ready; drives reg_cmd, reg_bytecount,
//   reg_data_in, reg_write, reg_read, tx_data, tx_valid. slave is the mirror (USB side + register bank).
interface cmd_engine_if #(
  parameter int LEN_BYTES = 2,
  parameter int CMD_BITS = 6
);
  localparam int BC_W = 8 * LEN_BYTES;
  logic byte_ready;
  logic [7:0] reg_usb_data_in;
  logic [CMD_BITS-1:0] reg_cmd;
  logic [BC_W-1:0] reg_bytecount;
  logic [7:0] reg_data_in;
  logic reg_write;
  logic reg_read;
  logic [7:0] reg_data_out;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master (
    input  byte_ready, reg_usb_data_in, reg_data_out, tx_ready,
    output reg_cmd, reg_bytecount, reg_data_in, reg_write, reg_read, tx_data, tx_valid
  );
  modport slave (
    output byte_ready, reg_usb_data_in, reg_data_out, tx_ready,
    input  reg_cmd, reg_bytecount, reg_data_in, reg_write, reg_read, tx_data, tx_valid
  );
endinterface

// File: rtl/cmd_engine.sv
// cmd_engine: USB byte-stream command decoder (header, LE length, data) driving a register bank
// Ports: clk_usb; reset_n (async, active-low); bus (cmd_engine_if.master) byte input, register-bank
//   strobes and tx valid/ready; busy (not IDLE); err_illegal / err_timeout one-cycle pulses.
// Define CMD_CHECKSUM_EN to expect a trailing XOR checksum byte on writes and add the err_checksum pulse.
module cmd_engine #(
  parameter int LEN_BYTES = 2,
  parameter int CMD_BITS = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk_usb,
  input  logic reset_n,
  cmd_engine_if.master bus,
  output logic busy,
  output logic err_illegal,
  output logic err_timeout
`ifdef CMD_CHECKSUM_EN
  ,
  output logic err_checksum
`endif
);
  localparam int BC_W = 8 * LEN_BYTES;
  typedef enum logic [2:0] {
    IDLE, LEN, WDATA, RREQ, RWAIT, RSEND
`ifdef CMD_CHECKSUM_EN
    , WCHK
`endif
  } state_t;
`ifdef CMD_CHECKSUM_EN
  localparam state_t WR_END = WCHK;
`else
  localparam state_t WR_END = IDLE;
`endif
  state_t state, state_n;
  logic [1:0] mode, mode_n, lidx, lidx_n;
  logic [BC_W-1:0] len, len_n, len_full, bc_n, idx;
  logic [CMD_BITS-1:0] cmd_n;
  logic [7:0] b, din_n, txd_n;
  logic wr_n, txv_n, eill_n, etmo_n, counting, last_len;
  logic [31:0] tmo, tmo_n;
`ifdef CMD_CHECKSUM_EN
  logic [7:0] chk, chk_n;
  logic echk_n;
`endif
  assign b = bus.reg_usb_data_in;
  assign busy = state != IDLE;
  assign bus.reg_read = state == RREQ;
  // index of the byte being handled: the counter advances the cycle after each write strobe
  assign idx = bus.reg_bytecount + BC_W'(bus.reg_write);
  assign len_full = len | (BC_W'(b) << {lidx, 3'b000});
  assign last_len = lidx == 2'(LEN_BYTES - 1);
`ifdef CMD_CHECKSUM_EN
  assign counting = TIMEOUT_CYCLES != 0 && (state == LEN || state == WDATA || state == WCHK);
`else
  assign counting = TIMEOUT_CYCLES != 0 && (state == LEN || state == WDATA);
`endif
  always_comb begin
    state_n = state;
    mode_n = mode;
    lidx_n = lidx;
    len_n = len;
    cmd_n = bus.reg_cmd;
    bc_n = idx;
    din_n = bus.reg_data_in;
    wr_n = 1'b0;
    txd_n = bus.tx_data;
    txv_n = bus.tx_valid;
    eill_n = 1'b0;
    etmo_n = 1'b0;
`ifdef CMD_CHECKSUM_EN
    chk_n = chk;
    echk_n = 1'b0;
    if (bus.byte_ready) chk_n = state == IDLE ? b : chk ^ b;
`endif
    case (state)
      IDLE: if (bus.byte_ready) begin
        state_n = LEN;
        mode_n = b[7:6];
        cmd_n = b[CMD_BITS-1:0];
        lidx_n = '0;
        len_n = '0;
        bc_n = '0;
      end
      LEN: if (bus.byte_ready) begin
        len_n = len_full;
        lidx_n = last_len ? 2'd0 : lidx + 2'd1;
        if (last_len) begin
          // zero length wins over mode decoding, so a zero-length illegal header is silent
          state_n = len_full == '0 ? (mode == 2'b11 ? WR_END : IDLE) :
                    mode == 2'b11 ? WDATA : mode == 2'b10 ? RREQ : IDLE;
          eill_n = len_full != '0 && !mode[1];
        end
      end
      WDATA: if (bus.byte_ready) begin
        wr_n = 1'b1;
        din_n = b;
        state_n = idx == len - 1'b1 ? WR_END : WDATA;
      end
      RREQ: state_n = RWAIT;
      RWAIT: begin
        txd_n = bus.reg_data_out;
        txv_n = 1'b1;
        state_n = RSEND;
      end
      RSEND: if (bus.tx_valid && bus.tx_ready) begin
        txv_n = 1'b0;
        state_n = idx == len - 1'b1 ? IDLE : RREQ;
        bc_n = idx == len - 1'b1 ? idx : idx + 1'b1;
      end
`ifdef CMD_CHECKSUM_EN
      WCHK: if (bus.byte_ready) begin
        echk_n = b != chk;
        state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
    if (counting && !bus.byte_ready && tmo == 32'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      etmo_n = 1'b1;
    end
    tmo_n = counting && !bus.byte_ready && state_n == state ? tmo + 32'd1 : '0;
  end
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      mode <= '0;
      lidx <= '0;
      len <= '0;
      tmo <= '0;
      bus.reg_cmd <= '0;
      bus.reg_bytecount <= '0;
      bus.reg_data_in <= '0;
      bus.reg_write <= 1'b0;
      bus.tx_data <= '0;
      bus.tx_valid <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      chk <= '0;
      err_checksum <= 1'b0;
`endif
    end else begin
      state <= state_n;
      mode <= mode_n;
      lidx <= lidx_n;
      len <= len_n;
      tmo <= tmo_n;
      bus.reg_cmd <= cmd_n;
      bus.reg_bytecount <= bc_n;
      bus.reg_data_in <= din_n;
      bus.reg_write <= wr_n;
      bus.tx_data <= txd_n;
      bus.tx_valid <= txv_n;
      err_illegal <= eill_n;
      err_timeout <= etmo_n;
`ifdef CMD_CHECKSUM_EN
      chk <= chk_n;
      err_checksum <= echk_n;
`endif
    end
  end
endmodule

// File: tb/tb_cmd_engine.sv
// tb_cmd_engine: randomized self-checking bench for cmd_engine against a transaction-level model
module tb_cmd_engine;
  logic clk_usb = 1'b0;
  logic reset_n = 1'b0;
  logic busy, err_illegal, err_timeout;
`ifdef CMD_CHECKSUM_EN
  logic err_checksum;
`endif
  int nchk = 0;
  int nerr = 0;
  int exp_ill = 0;
  int exp_tmo = 0;
  int n_ill = 0;
  int n_tmo = 0;
  int n_echk = 0;
  int bpm = 0;
  logic [7:0] mem [256];
  logic [7:0] pay [300];
  logic [23:0] exp_wr [$];
  logic [15:0] exp_rd [$];
  logic [7:0] exp_tx [$];

  cmd_engine_if #(.LEN_BYTES(2), .CMD_BITS(6)) bus ();

  cmd_engine #(.LEN_BYTES(2), .CMD_BITS(6), .TIMEOUT_CYCLES(16)) dut (
    .clk_usb(clk_usb),
    .reset_n(reset_n),
    .bus(bus),
    .busy(busy),
    .err_illegal(err_illegal),
    .err_timeout(err_timeout)
`ifdef CMD_CHECKSUM_EN
    ,
    .err_checksum(err_checksum)
`endif
  );

  always #5 clk_usb = ~clk_usb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    bus.byte_ready = 1'b1;
    bus.reg_usb_data_in = v;
    @(posedge clk_usb);
    #1;
    bus.byte_ready = 1'b0;
    bus.reg_usb_data_in = 8'($urandom);
    repeat (gap) begin
      @(posedge clk_usb);
      #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk_usb);
      n++;
    end
    check("idle_reached", busy, 0);
    repeat (2) @(negedge clk_usb);
  endtask

  task automatic check_totals();
    check("wr_left", exp_wr.size(), 0);
    check("rd_left", exp_rd.size(), 0);
    check("tx_left", exp_tx.size(), 0);
    check("illegal_count", n_ill, exp_ill);
    check("timeout_count", n_tmo, exp_tmo);
`ifdef CMD_CHECKSUM_EN
    check("checksum_errs", n_echk, 0);
`endif
  endtask

  // model: a command's effects follow from header mode and length alone
  task automatic run_cmd(input logic [7:0] hdr, input int len, input int mode_bp);
    logic [7:0] cs;
    logic [15:0] l;
    cs = hdr;
    l = 16'(len);
    bpm = mode_bp;
    if (len != 0) begin
      if (hdr[7:6] == 2'b11) for (int i = 0; i < len; i++) exp_wr.push_back({16'(i), pay[i]});
      else if (hdr[7:6] == 2'b10) for (int i = 0; i < len; i++) begin
        exp_rd.push_back(16'(i));
        exp_tx.push_back(mem[i]);
      end
      else exp_ill++;
    end
    send_byte(hdr, $urandom_range(0, 3));
    check("reg_cmd", bus.reg_cmd, {26'd0, hdr[5:0]});
    send_byte(l[7:0], $urandom_range(0, 3));
    cs ^= l[7:0];
    send_byte(l[15:8], (hdr[7:6] == 2'b10 && mode_bp == 1) ? 0 : $urandom_range(0, 3));
    cs ^= l[15:8];
    if (hdr[7:6] == 2'b10 && mode_bp == 1 && len != 0) send_byte(8'hE7, 0);
    if (hdr[7:6] == 2'b11) begin
      for (int i = 0; i < len; i++) begin
        send_byte(pay[i], $urandom_range(0, 3));
        cs ^= pay[i];
      end
`ifdef CMD_CHECKSUM_EN
      send_byte(cs, 0);
`endif
    end
    wait_idle(3000);
    check_totals();
  endtask

  initial begin
    int vc;
    vc = 0;
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk_usb);
      #2;
      vc = bus.tx_valid ? vc + 1 : 0;
      bus.tx_ready = bpm == 0 ? ($urandom_range(0, 3) == 0) : bpm == 1 ? (vc > 5) : 1'b0;
    end
  end

  initial begin
    logic rd;
    logic [7:0] ix;
    bus.reg_data_out = 8'h00;
    forever begin
      @(negedge clk_usb);
      rd = bus.reg_read;
      ix = bus.reg_bytecount[7:0];
      @(posedge clk_usb);
      #1;
      bus.reg_data_out = rd ? mem[ix] : 8'($urandom);
    end
  end

  initial begin
    logic pv, pacc, acc;
    logic [7:0] pd, et;
    logic [23:0] ew;
    logic [15:0] er;
    pv = 1'b0;
    pacc = 1'b0;
    pd = 8'h00;
    forever begin
      @(negedge clk_usb);
      if (!reset_n) pv = 1'b0;
      else begin
        if (bus.reg_write || bus.reg_read) check("wr_rd_excl", {31'd0, bus.reg_write & bus.reg_read}, 0);
        if (bus.reg_write) begin
          ew = exp_wr.size() != 0 ? exp_wr.pop_front() : 'x;
          check("write", {8'd0, bus.reg_bytecount, bus.reg_data_in}, {8'd0, ew});
        end
        if (bus.reg_read) begin
          er = exp_rd.size() != 0 ? exp_rd.pop_front() : 'x;
          check("read_idx", {16'd0, bus.reg_bytecount}, {16'd0, er});
        end
        if (pv && !pacc) check("tx_hold", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, pd});
        acc = bus.tx_valid && bus.tx_ready;
        if (acc) begin
          et = exp_tx.size() != 0 ? exp_tx.pop_front() : 'x;
          check("tx_data", {24'd0, bus.tx_data}, {24'd0, et});
        end
        pv = bus.tx_valid;
        pd = bus.tx_data;
        pacc = acc;
        if (err_illegal) n_ill++;
        if (err_timeout) n_tmo++;
`ifdef CMD_CHECKSUM_EN
        if (err_checksum) n_echk++;
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
    $fatal(1);
  end

  initial begin
    int n, m, len;
    bus.byte_ready = 1'b0;
    bus.reg_usb_data_in = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk_usb);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_strobes", {27'd0, bus.reg_write, bus.reg_read, bus.tx_valid, err_illegal, err_timeout}, 0);
    check("rst_cmd_bc", {10'd0, bus.reg_cmd, bus.reg_bytecount}, 0);
    check("rst_data", {16'd0, bus.tx_data, bus.reg_data_in}, 0);
    @(posedge clk_usb);
    #1;
    reset_n = 1'b1;
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
    run_cmd(8'hC5, 3, 0);
    mem[0] = 8'h11; mem[1] = 8'h22;
    run_cmd(8'h8A, 2, 1);
    run_cmd(8'hC1, 0, 0);
    pay[0] = 8'h77;
    run_cmd(8'hC2, 1, 0);
    run_cmd(8'h41, 1, 0);
    pay[0] = 8'h3C; pay[1] = 8'hC3;
    run_cmd(8'hC4, 2, 0);
    exp_wr.push_back({16'd0, 8'h55});
    exp_tmo++;
    send_byte(8'hC3, 1);
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    send_byte(8'h55, 0);
    n = 0;
    while (!err_timeout && n < 40) begin
      @(negedge clk_usb);
      n++;
    end
    check("timeout_latency", n, 17);
    check("timeout_busy", {31'd0, busy}, 0);
    repeat (2) @(negedge clk_usb);
    check_totals();
    for (int i = 0; i < 260; i++) pay[i] = 8'($urandom);
    run_cmd(8'hC0 | 8'($urandom_range(0, 63)), 260, 0);
    for (int k = 0; k < 40; k++) begin
      m = $urandom_range(0, 9);
      len = $urandom_range(0, 4);
      for (int i = 0; i < 8; i++) begin
        mem[i] = 8'($urandom);
        pay[i] = 8'($urandom);
      end
      run_cmd({m < 4 ? 2'b11 : m < 8 ? 2'b10 : 2'($urandom_range(0, 1)), 6'($urandom)}, len, $urandom_range(0, 1));
    end
    bpm = 2;
    mem[0] = 8'h5A;
    exp_rd.push_back(16'd0);
    send_byte(8'h8A, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    n = 0;
    while (!bus.tx_valid && n < 20) begin
      @(negedge clk_usb);
      n++;
    end
    check("rr_valid_up", {31'd0, bus.tx_valid}, 1);
    check("rr_data", {24'd0, bus.tx_data}, 32'h5A);
    #2;
    reset_n = 1'b0;
    #1;
    check("rr_txvalid", {31'd0, bus.tx_valid}, 0);
    check("rr_busy", {31'd0, busy}, 0);
    check("rr_cmd", {26'd0, bus.reg_cmd}, 0);
    exp_rd.delete();
    exp_tx.delete();
    repeat (2) @(posedge clk_usb);
    #1;
    reset_n = 1'b1;
    bpm = 0;
    pay[0] = 8'h01; pay[1] = 8'h80; pay[2] = 8'hFE;
    run_cmd(8'hC9, 3, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
